power_converter_ramp: RTL
=========================

# power_converter_ramp

Parametrised successor to the fixed ×2 converter model. It scales the input sample by a programmable gain, saturates the result to the output width, and slew-limits the output. Soft-start, power-good and an over-voltage fault latch are controlled by a 4-state FSM. It sits between the input-sense sample bus and the output drive/telemetry path.

## Interface
- WIDTH, 8: width of vin and vout.
- GAIN_W, 3: width of gain; multiplier range is 0..2^GAIN_W-1.
- STEP, 4: maximum |Δvout| per clock (slew limit), 1..2^WIDTH-1.
- OV_LIMIT, 240: vin strictly above this value counts as over-voltage.
- OV_CYCLES, 3: consecutive over-voltage cycles that trip the fault, ≥1.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- en  in  1  converter enable.
- vin  in  WIDTH  input voltage sample, unsigned.
- gain  in  GAIN_W  gain multiplier, unsigned.
- vout  out  WIDTH  output voltage, registered.
- pgood  out  1  power good, registered.
- fault  out  1  over-voltage fault latched, registered.
- state  out  2  FSM state: 0 IDLE, 1 RAMP, 2 REG, 3 FAULT.

## Operation
- target = min(vin*gain, 2^WIDTH-1).
  - Full product width is WIDTH+GAIN_W; saturate, never wrap.
  - target is evaluated combinationally from the current inputs each cycle.
- Slew step, used in RAMP and REG:
  - If |target−vout| ≤ STEP: vout := target.
  - Otherwise vout moves STEP toward target, up or down.
- IDLE:
  - vout=0, pgood=0, fault=0.
  - en=1 → RAMP. vout stays 0 on this transition edge.
- RAMP:
  - Apply one slew step per cycle.
  - If the post-step vout equals target → REG on that same edge.
- REG:
  - Apply one slew step per cycle, so vout keeps tracking target changes at the slew limit.
  - Remain in REG even while temporarily off target.
- FAULT:
  - vout=0, fault=1, pgood=0.
  - Leave only when en=0 → IDLE. Staying in FAULT with en=1 is the required latch behaviour.
- Over-voltage counter ov_cnt:
  - Active only in RAMP/REG.
  - Increments when vin>OV_LIMIT; clears when vin≤OV_LIMIT or in any other state.
  - On an edge where vin>OV_LIMIT and ov_cnt==OV_CYCLES−1: → FAULT, vout:=0, ov_cnt:=0.
- Priority on each edge: reset > OV trip > en=0 > normal transition.
  - en=0 in RAMP/REG → IDLE with vout:=0 on the same edge (hard off, no ramp-down).
  - OV trip and en=0 on the same edge → FAULT.
- pgood is 1 exactly when the registered state is REG.
- fault is 1 exactly when the registered state is FAULT.
- gain=0 gives target=0. RAMP with target 0 and vout 0 → REG on the first RAMP edge.

## Timing
- Reset: every output updates on the first rising edge with rst_n=0.
  - Values: vout=0, pgood=0, fault=0, state=IDLE, ov_cnt=0.
  - Reset applies from any state, including mid-ramp or FAULT.
- All outputs are registered. An input change is visible on outputs one edge later; there is no combinational input-to-output path.
- Soft-start latency: 1 edge IDLE→RAMP, then ceil(target/STEP) edges to REG. pgood rises on the edge where vout reaches target.
- Fault latency: the OV_CYCLES-th consecutive edge sampling vin>OV_LIMIT is the one that enters FAULT.
- en: an en=0 edge exits to IDLE; a subsequent en=1 edge re-enters RAMP from vout=0.

## Test plan
- Reset mid-operation:
  - Stimulus: drive to REG with vout=200, then hold rst_n=0 for 1 edge.
  - Required: next edge shows vout=0, pgood=0, fault=0, state=0; en=1 afterwards restarts the ramp from 0.
- Soft-start:
  - Stimulus: en=1, vin=100, gain=2.
  - Required: RAMP entered on edge 1; vout=4,8,…,200 on edges 2–51; state=2 and pgood=1 on edge 51.
- Saturation and clipping step:
  - Stimulus: vin=200, gain=3 (product 600).
  - Required: target=255; ramp ends with vout 252→255 on the clipped final step, then REG.
- Slew tracking in REG:
  - Stimulus: from REG at vout=200, change gain to 1 (target 100).
  - Required: vout=196,192,…,100 over 25 edges; pgood stays 1 throughout.
- OV fault:
  - Stimulus: in REG, vin=241 for 2 edges, then 240 for 1 edge, then 241 for 3 edges.
  - Required: no fault through the first 3 edges; FAULT entered on the 3rd consecutive 241 edge with vout=0, fault=1.
  - Required: with en=1 the block stays in FAULT; en=0 gives IDLE on the next edge.
- Enable drop and simultaneous events:
  - Stimulus: en=0 during RAMP at vout=40.
  - Required: IDLE with vout=0 on the next edge.
  - Stimulus: en=0 on the same edge as the OV trip.
  - Required: FAULT.

Source files
------------

// File: rtl/power_converter_ramp_if.sv
`default_nettype none
// ============================================================================
// Module      : power_converter_ramp_if
// Description : Sense-sample / drive-telemetry bundle for power_converter_ramp.
// Revision    : 1.0 - initial release
// ============================================================================
interface power_converter_ramp_if #(
  parameter int WIDTH  = 8,
  parameter int GAIN_W = 3
);
  logic              en;
  logic [WIDTH-1:0]  vin;
  logic [GAIN_W-1:0] gain;
  logic [WIDTH-1:0]  vout;
  logic              pgood;
  logic              fault;
  logic [1:0]        state;

  modport master (
    output en, vin, gain,
    input  vout, pgood, fault, state
  );

  modport slave (
    input  en, vin, gain,
    output vout, pgood, fault, state
  );
endinterface
`default_nettype wire

// File: rtl/power_converter_ramp.sv
`default_nettype none
// ============================================================================
// Module      : power_converter_ramp
// Description : Gain/saturate/slew-limited converter with soft-start,
//               power-good and latched over-voltage fault.
// Revision    : 1.0 - initial release
// ============================================================================
module power_converter_ramp #(
  parameter int WIDTH     = 8,
  parameter int GAIN_W    = 3,
  parameter int STEP      = 4,
  parameter int OV_LIMIT  = 240,
  parameter int OV_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  power_converter_ramp_if.slave      conv_io
);

  localparam int PROD_W = WIDTH + GAIN_W;
  localparam int CNT_W  = (OV_CYCLES > 1) ? $clog2(OV_CYCLES) : 1;

  localparam logic [PROD_W-1:0] c_MAX_P    = {{GAIN_W{1'b0}}, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0]  c_STEP     = WIDTH'(STEP);
  localparam logic [WIDTH-1:0]  c_OV_LIMIT = WIDTH'(OV_LIMIT);
  localparam logic [CNT_W-1:0]  c_OV_LAST  = CNT_W'(OV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RAMP  = 2'd1,
    S_REG   = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   vout_q, vout_d;
  logic [CNT_W-1:0]   ov_cnt_q, ov_cnt_d;
  logic               pgood_q, fault_q;

  logic [PROD_W-1:0]  w_prod;
  logic [WIDTH-1:0]   w_target;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_slew;
  logic               w_ov;

  // Full-width product so the saturation compare never sees a wrapped value.
  assign w_prod   = {{GAIN_W{1'b0}}, conv_io.vin} * {{WIDTH{1'b0}}, conv_io.gain};
  assign w_target = (w_prod > c_MAX_P) ? {WIDTH{1'b1}} : w_prod[WIDTH-1:0];
  assign w_ov     = (conv_io.vin > c_OV_LIMIT);

  always_comb begin
    w_diff = '0;
    w_slew = vout_q;
    if (w_target >= vout_q) begin
      w_diff = w_target - vout_q;
      w_slew = (w_diff <= c_STEP) ? w_target : (vout_q + c_STEP);
    end else begin
      w_diff = vout_q - w_target;
      w_slew = (w_diff <= c_STEP) ? w_target : (vout_q - c_STEP);
    end
  end

  always_comb begin
    state_d  = state_q;
    vout_d   = vout_q;
    ov_cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        vout_d = '0;
        if (conv_io.en) state_d = S_RAMP;
      end
      S_RAMP, S_REG: begin
        // OV trip outranks enable drop on the same edge.
        if (w_ov && (ov_cnt_q == c_OV_LAST)) begin
          state_d = S_FAULT;
          vout_d  = '0;
        end else if (!conv_io.en) begin
          state_d = S_IDLE;
          vout_d  = '0;
        end else begin
          vout_d   = w_slew;
          ov_cnt_d = w_ov ? (ov_cnt_q + 1'b1) : '0;
          if ((state_q == S_RAMP) && (w_slew == w_target)) state_d = S_REG;
        end
      end
      S_FAULT: begin
        vout_d = '0;
        if (!conv_io.en) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        vout_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vout_q   <= '0;
      ov_cnt_q <= '0;
      pgood_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      vout_q   <= vout_d;
      ov_cnt_q <= ov_cnt_d;
      pgood_q  <= (state_d == S_REG);
      fault_q  <= (state_d == S_FAULT);
    end
  end

  assign conv_io.vout  = vout_q;
  assign conv_io.pgood = pgood_q;
  assign conv_io.fault = fault_q;
  assign conv_io.state = state_q;

endmodule
`default_nettype wire
